// File: rtl/ifetch_pkg.sv
// Shared widths and the queue entry type for the instruction-fetch slice.
package ifetch_pkg;

    localparam int DSIZE    = 16;  // word address width
    localparam int ISIZE    = 32;  // instruction width
    localparam int IQ_DEPTH = 4;   // default instruction queue depth

    typedef struct packed {
        logic [DSIZE-1:0] pc;
        logic [ISIZE-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// In-order instruction queue holding {pc, inst} pairs, with flush and a same-cycle push/pop path.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: storage has no reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch initiator: owns the PC, issues one word address per cycle under a credit limit,
// absorbs the memory's 1-cycle latency and feeds decode through ifetch_queue.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [DSIZE-1:0] RESET_PC = 16'h0000,
    parameter int               QDEPTH   = IQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [DSIZE-1:0]  redirect_pc,
    output logic [DSIZE-1:0]  mem_addr,
    output logic              mem_wen,
    output logic [DSIZE-1:0]  mem_wdata,
    input  logic [ISIZE-1:0]  mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ISIZE-1:0]  inst_data,
    output logic [DSIZE-1:0]  inst_pc
);

    localparam int              CW      = $clog2(QDEPTH) + 1;
    localparam logic [CW:0]     QDEPTH_L = (CW + 1)'(QDEPTH);

    logic [DSIZE-1:0]  r_pc;
    logic              r_inflight;
    logic [DSIZE-1:0]  r_inflight_pc;

    logic [DSIZE-1:0]  w_mem_addr;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    assign mem_wen   = 1'b0;
    assign mem_wdata = '0;

    assign w_mem_addr = redirect ? redirect_pc : r_pc;
    assign mem_addr   = w_mem_addr;

    // Redirect empties the queue and drops the in-flight word, so credit is judged on zero occupancy.
    assign w_occupancy = redirect ? '0 : ({1'b0, w_count} + (CW + 1)'(r_inflight));
    assign w_issue     = fetch_en & (w_occupancy < QDEPTH_L);

    assign w_push      = r_inflight & ~redirect;
    assign w_pop       = inst_valid & inst_ready;
    assign w_push_data = '{pc: r_inflight_pc, inst: mem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else if (w_issue) begin
            r_inflight_pc <= w_mem_addr;
            r_inflight    <= 1'b1;
            r_pc          <= w_mem_addr + 1'b1;
        end else begin
            // Without an issue the PC holds, except that a redirect target is kept for later.
            r_inflight <= 1'b0;
            r_pc       <= w_mem_addr;
        end
    end

    ifetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign inst_valid = ~w_empty;
    assign inst_data  = w_head.inst;
    assign inst_pc    = w_head.pc;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        w_push |-> (!w_full || w_pop));

endmodule
